ofdm_subcarrier_sched: RTL



---
 rtl/ofdm_subcarrier_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ofdm_subcarrier_sched.sv
// OFDM subcarrier scheduler: merges upstream data, alternating pilots and
// guard nulls into one NFFT-sample symbol stream for the IFFT input.
module ofdm_subcarrier_sched #(
  parameter int WIDTH         = 8,
  parameter int NFFT          = 16,
  parameter int NGUARD        = 2,
  parameter int PILOT_SPACING = 4,
  parameter logic [WIDTH-1:0] PILOT_VALUE = WIDTH'(8'h7F)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             o_ready,
  output logic [15:0]      sym_count,
  output logic             busy
);

  localparam int KW = $clog2(NFFT);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             pilot_sign_q, pilot_sign_d;
  logic [15:0]      sym_count_q, sym_count_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d;
  logic             o_last_q, o_last_d;

  logic [31:0]      k_ext;
  logic             is_null;
  logic             is_pilot;
  logic             is_data;
  logic             k_last;
  logic             load;
  logic             avail;
  logic [WIDTH-1:0] slot_val;
  logic [WIDTH-1:0] pilot_val;

  // Slot classification is a pure function of the position in the symbol
  assign k_ext    = 32'(k_q);
  assign is_null  = (k_ext < 32'(NGUARD)) ||
                    (k_ext >= 32'(NFFT - NGUARD));
  assign is_pilot = !is_null &&
                    (((k_ext - 32'(NGUARD)) % 32'(PILOT_SPACING)) == 32'd0);
  assign is_data  = !is_null && !is_pilot;
  assign k_last   = (k_q == KW'(NFFT - 1));

  assign load  = !o_valid_q || o_ready;
  assign avail = !is_data || d_valid;

  assign pilot_val = pilot_sign_q ? (WIDTH'(0) - PILOT_VALUE) : PILOT_VALUE;

  always_comb begin
    slot_val = '0;
    unique case (1'b1)
      is_null:  slot_val = '0;
      is_pilot: slot_val = pilot_val;
      default:  slot_val = d_data;
    endcase
  end

  assign d_ready = !rst && (state_q == RUN) && is_data && load;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    pilot_sign_d = pilot_sign_q;
    sym_count_d  = sym_count_q;
    o_data_d     = o_data_q;
    o_valid_d    = o_valid_q;
    o_last_d     = o_last_q;
    unique case (state_q)
      IDLE: begin
        if (o_valid_q && o_ready) begin
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
        end
        if (en) begin
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        if (load && avail) begin
          o_data_d  = slot_val;
          o_valid_d = 1'b1;
          o_last_d  = k_last;
          if (k_last) begin
            k_d          = '0;
            pilot_sign_d = !pilot_sign_q;
            sym_count_d  = sym_count_q + 16'd1;
            if (!en) state_d = IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else if (load) begin
          // Starved data slot: bubble rather than filler
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      pilot_sign_q <= 1'b0;
      sym_count_q  <= '0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pilot_sign_q <= pilot_sign_d;
      sym_count_q  <= sym_count_d;
      o_data_q     <= o_data_d;
      o_valid_q    <= o_valid_d;
      o_last_q     <= o_last_d;
    end
  end

  assign o_data    = o_data_q;
  assign o_valid   = o_valid_q;
  assign o_last    = o_last_q;
  assign sym_count = sym_count_q;
  assign busy      = (state_q == RUN);

endmodule
